// File: rtl/modulo_matriz_pkg.sv
// Shared constants, load FSM state type and column mask helper for the
// 5x7 matrix display controller.
package modulo_matriz_pkg;

    localparam int COLS = 5;
    localparam int ROWS = 7;
    localparam int BITS = 35;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Seven-bit write-enable window for column c: bits [34-7c : 28-7c].
    function automatic logic [BITS-1:0] col_mask(input logic [2:0] c);
        logic [BITS-1:0] base;
        base = {{(BITS-ROWS){1'b0}}, {ROWS{1'b1}}};
        if (int'(c) >= COLS) begin
            return '0;
        end
        return base << (BITS - ROWS * (int'(c) + 1));
    endfunction

endpackage

// File: rtl/modulo_varredura_colunas.sv
// Column scanner: dwell counter, column index and registered column/row
// drivers, with blanking that freezes the row lines but not the scan.
module modulo_varredura_colunas
    import modulo_matriz_pkg::*;
#(
    parameter int DWELL = 1000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             blank,
    input  logic [BITS-1:0]  reg_q,
    output logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       col_q, col_d;
    logic [COLS-1:0]  col_n_q, col_n_d;
    logic [ROWS-1:0]  row_q, row_d;

    logic [COLS-1:0]  onehot_w;
    logic [ROWS-1:0]  slice_w [COLS];
    logic [ROWS-1:0]  row_sel;

    // Row 0 of each column is the most significant bit of its slice.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign onehot_w[gi] = (col_q == 3'(gi));
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
            assign slice_w[gi][gr] = reg_q[BITS - 1 - ROWS * gi - gr];
        end
    end

    always_comb begin
        row_sel = '1;
        for (int c = 0; c < COLS; c++) begin
            if (onehot_w[c]) begin
                row_sel = slice_w[c];
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        col_d   = col_q;
        col_n_d = ~onehot_w;
        row_d   = row_sel;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            col_d = (col_q == 3'(COLS - 1)) ? 3'd0 : col_q + 3'd1;
        end
        if (blank) begin
            col_n_d = '1;
            row_d   = row_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q   <= '0;
            col_q   <= '0;
            col_n_q <= '1;
            row_q   <= '1;
        end else begin
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            col_n_q <= col_n_d;
            row_q   <= row_d;
        end
    end

    assign col_n = col_n_q;
    assign row   = row_q;

endmodule

// File: rtl/modulo_ctrl_matriz.sv
// Matrix register controller: loads a 35-bit pattern one column per cycle
// and scans the stored pattern onto the column/row display lines.
module modulo_ctrl_matriz
    import modulo_matriz_pkg::*;
#(
    parameter int DWELL = 1000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_req,
    input  logic [BITS-1:0]  wr_data,
    output logic             wr_ack,
    output logic             busy,
    output logic [BITS-1:0]  ld,
    output logic [BITS-1:0]  reg_d,
    input  logic [BITS-1:0]  reg_q,
    output logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row
);

    state_t          state_q, state_d;
    logic [2:0]      k_q, k_d;
    logic [BITS-1:0] shadow_q, shadow_d;
    logic [BITS-1:0] ld_q, ld_d;
    logic            wr_ack_q, wr_ack_d;
    logic            busy_q, busy_d;

    // Outputs are computed for the state being entered so they line up
    // with the registered state.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        ld_d     = '0;
        wr_ack_d = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (wr_req) begin
                    state_d  = LOAD;
                    k_d      = 3'd0;
                    shadow_d = wr_data;
                    ld_d     = col_mask(3'd0);
                    wr_ack_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            LOAD: begin
                if (k_q == 3'(COLS - 1)) begin
                    state_d = IDLE;
                    k_d     = 3'd0;
                    busy_d  = 1'b0;
                end else begin
                    k_d    = k_q + 3'd1;
                    ld_d   = col_mask(k_q + 3'd1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            k_q      <= '0;
            shadow_q <= '1;
            ld_q     <= '0;
            wr_ack_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            ld_q     <= ld_d;
            wr_ack_q <= wr_ack_d;
            busy_q   <= busy_d;
        end
    end

    assign wr_ack = wr_ack_q;
    assign busy   = busy_q;
    assign ld     = ld_q;
    assign reg_d  = shadow_q;

    // Blanking follows the next busy value so col_n blanks in exactly the
    // cycles where busy is high.
    modulo_varredura_colunas #(
        .DWELL (DWELL)
    ) u_varredura (
        .clk   (clk),
        .clr   (clr),
        .blank (busy_d),
        .reg_q (reg_q),
        .col_n (col_n),
        .row   (row)
    );

endmodule

// File: tb/tb_modulo_ctrl_matriz.sv
// Directed bench for modulo_ctrl_matriz: load sequencing, back-to-back
// requests, column scan, blanking and reset abort.
module tb_modulo_ctrl_matriz;

    logic        clk;
    logic        clr;
    logic        wr_req;
    logic [34:0] wr_data;
    logic [34:0] reg_q;

    logic        wr_ack, busy;
    logic [34:0] ld, reg_d;
    logic [4:0]  col_n;
    logic [6:0]  row;

    logic        wr_ack1, busy1;
    logic [34:0] ld1, reg_d1;
    logic [4:0]  col_n1;
    logic [6:0]  row1;

    int total = 0;
    int bad   = 0;

    logic [34:0] exp_ld [5];

    modulo_ctrl_matriz #(.DWELL(4)) dut (
        .clk(clk), .clr(clr), .wr_req(wr_req), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .ld(ld), .reg_d(reg_d),
        .reg_q(reg_q), .col_n(col_n), .row(row)
    );

    modulo_ctrl_matriz #(.DWELL(1)) dut1 (
        .clk(clk), .clr(clr), .wr_req(wr_req), .wr_data(wr_data),
        .wr_ack(wr_ack1), .busy(busy1), .ld(ld1), .reg_d(reg_d1),
        .reg_q(reg_q), .col_n(col_n1), .row(row1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr    = 1'b1;
        wr_req = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr     = 1'b1;
        wr_req  = 1'b1;
        wr_data = 35'h0;
        reg_q   = '1;
        tick();
        wr_req = 1'b0;
        total++; if (ld !== 35'h0) begin bad++; $display("FAIL reset_ld got=%h want=%h", ld, 35'h0); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack got=%b want=0", wr_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (reg_d !== 35'h7FFFFFFFF) begin bad++; $display("FAIL reset_reg_d got=%h want=%h", reg_d, 35'h7FFFFFFFF); end
        total++; if (col_n !== 5'b11111) begin bad++; $display("FAIL reset_col_n got=%b want=11111", col_n); end
        total++; if (row !== 7'b1111111) begin bad++; $display("FAIL reset_row got=%b want=1111111", row); end
        clr = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_req_discard busy got=%b want=0", busy); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_req_discard wr_ack got=%b want=0", wr_ack); end
        $display("test_reset: done");
    endtask

    task automatic test_single_load();
        int busy_cnt;
        do_reset();
        wr_data = 35'h0;
        wr_req  = 1'b1;
        tick();
        wr_req   = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            total++; if (ld !== exp_ld[k]) begin bad++; $display("FAIL load_ld[%0d] got=%h want=%h", k, ld, exp_ld[k]); end
            total++; if (wr_ack !== (k == 0)) begin bad++; $display("FAIL load_wr_ack[%0d] got=%b want=%b", k, wr_ack, (k == 0)); end
            total++; if (reg_d !== 35'h0) begin bad++; $display("FAIL load_reg_d[%0d] got=%h want=0", k, reg_d); end
            if (busy === 1'b1) busy_cnt++;
            $display("load cycle %0d: ld=%h busy=%b wr_ack=%b", k, ld, busy, wr_ack);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (busy === 1'b1) busy_cnt++;
            total++; if (ld !== 35'h0) begin bad++; $display("FAIL load_idle_ld got=%h want=0", ld); end
            tick();
        end
        total++; if (busy_cnt != 5) begin bad++; $display("FAIL load_busy_cycles got=%0d want=5", busy_cnt); end
    endtask

    task automatic test_back_to_back();
        int acks, first_at, second_at;
        do_reset();
        wr_data   = 35'h2AAAAAAAA;
        wr_req    = 1'b1;
        acks      = 0;
        first_at  = -1;
        second_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 11) wr_req = 1'b0;
            if (wr_ack === 1'b1) begin
                acks++;
                if (first_at < 0) first_at = i;
                else if (second_at < 0) second_at = i;
                total++; if (reg_d !== 35'h2AAAAAAAA) begin bad++; $display("FAIL b2b_reg_d got=%h want=%h", reg_d, 35'h2AAAAAAAA); end
            end
        end
        $display("back_to_back: acks=%0d at %0d and %0d", acks, first_at, second_at);
        total++; if (acks != 2) begin bad++; $display("FAIL b2b_ack_count got=%0d want=2", acks); end
        total++; if (second_at - first_at != 6) begin bad++; $display("FAIL b2b_ack_spacing got=%0d want=6", second_at - first_at); end
    endtask

    task automatic test_scan();
        int c;
        logic [4:0] e_col;
        logic [6:0] e_row;
        reg_q = 35'h7FFFFFFFF;
        reg_q[27] = 1'b0;
        do_reset();
        for (int i = 1; i <= 21; i++) begin
            tick();
            c     = ((i - 1) / 4) % 5;
            e_col = ~(5'd1 << c);
            e_row = (c == 1) ? 7'b1111110 : 7'b1111111;
            total++; if (col_n !== e_col) begin bad++; $display("FAIL scan_col_n[%0d] got=%b want=%b", i, col_n, e_col); end
            total++; if (row !== e_row) begin bad++; $display("FAIL scan_row[%0d] got=%b want=%b", i, row, e_row); end
            $display("scan cycle %0d: col_n=%b row=%b", i, col_n, row);
        end
    endtask

    task automatic test_blank_resume();
        int c;
        logic [4:0] e_col;
        reg_q = 35'h7FFFFFFFF;
        do_reset();
        for (int i = 1; i <= 10; i++) tick();
        total++; if (col_n !== 5'b11011) begin bad++; $display("FAIL blank_pre_col_n got=%b want=11011", col_n); end
        reg_q   = 35'h0;
        wr_data = 35'h0;
        wr_req  = 1'b1;
        for (int i = 11; i <= 15; i++) begin
            tick();
            wr_req = 1'b0;
            total++; if (col_n !== 5'b11111) begin bad++; $display("FAIL blank_col_n[%0d] got=%b want=11111", i, col_n); end
            total++; if (row !== 7'b1111111) begin bad++; $display("FAIL blank_row_hold[%0d] got=%b want=1111111", i, row); end
            $display("blank cycle %0d: col_n=%b busy=%b", i, col_n, busy);
        end
        reg_q = 35'h7FFFFFFFF;
        for (int i = 16; i <= 20; i++) begin
            tick();
            c     = ((i - 1) / 4) % 5;
            e_col = ~(5'd1 << c);
            total++; if (col_n !== e_col) begin bad++; $display("FAIL resume_col_n[%0d] got=%b want=%b", i, col_n, e_col); end
        end
    endtask

    task automatic test_clr_abort();
        do_reset();
        wr_data = 35'h123456789;
        wr_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        tick();
        total++; if (ld !== 35'h0001FC000) begin bad++; $display("FAIL abort_third_ld got=%h want=%h", ld, 35'h0001FC000); end
        clr    = 1'b1;
        wr_req = 1'b1;
        tick();
        total++; if (ld !== 35'h0) begin bad++; $display("FAIL abort_ld got=%h want=0", ld); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (col_n !== 5'b11111) begin bad++; $display("FAIL abort_col_n got=%b want=11111", col_n); end
        clr    = 1'b0;
        wr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL abort_no_ack[%0d] got=%b want=0", i, wr_ack); end
            total++; if (ld !== 35'h0) begin bad++; $display("FAIL abort_no_ld[%0d] got=%h want=0", i, ld); end
        end
        $display("clr_abort: done");
    endtask

    task automatic test_dwell_one();
        logic [4:0] e_col;
        reg_q = 35'h7FFFFFFFF;
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            tick();
            e_col = ~(5'd1 << ((i - 1) % 5));
            total++; if (col_n1 !== e_col) begin bad++; $display("FAIL dwell1_col_n[%0d] got=%b want=%b", i, col_n1, e_col); end
            $display("dwell1 cycle %0d: col_n=%b", i, col_n1);
        end
        total++; if (row1 !== 7'b1111111) begin bad++; $display("FAIL dwell1_row got=%b want=1111111", row1); end
        total++; if ({busy1, wr_ack1} !== 2'b00) begin bad++; $display("FAIL dwell1_idle got=%b want=00", {busy1, wr_ack1}); end
        total++; if (ld1 !== 35'h0) begin bad++; $display("FAIL dwell1_ld got=%h want=0", ld1); end
        total++; if (reg_d1 !== 35'h7FFFFFFFF) begin bad++; $display("FAIL dwell1_reg_d got=%h want=%h", reg_d1, 35'h7FFFFFFFF); end
    endtask

    initial begin
        exp_ld[0] = 35'h7F0000000;
        exp_ld[1] = 35'h00FE00000;
        exp_ld[2] = 35'h0001FC000;
        exp_ld[3] = 35'h000003F80;
        exp_ld[4] = 35'h00000007F;
        clr     = 1'b1;
        wr_req  = 1'b0;
        wr_data = 35'h0;
        reg_q   = '1;
        test_reset();
        test_single_load();
        test_back_to_back();
        test_scan();
        test_blank_resume();
        test_clr_abort();
        test_dwell_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
